crc32_fcs_ctrl: RTL and testbench

CRC32_FCS_CTRL -- requirements
Module: crc32_fcs_ctrl

---
 rtl/crc_pkg.sv | 18 +
 rtl/crc32.sv | 26 ++
 rtl/crc32_fcs_ctrl.sv | 131 +++++++++++++
 tb/tb_crc32_fcs_ctrl.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/crc_pkg.sv
// Shared constants and types for the CRC-32 FCS insertion block.
package crc_pkg;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned CRC_WIDTH  = 32;
  localparam logic [31:0] CRC_INIT   = 32'hFFFF_FFFF;
  // Reflected form of 0x04C11DB7; bytes enter LSB first.
  localparam logic [31:0] CRC_POLY   = 32'hEDB8_8320;

  typedef enum logic [1:0] {StIdle, StData, StTail} fcs_state_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0]   data_word;
    logic [DATA_WIDTH/8-1:0] data_valid;
    logic                    last;
  } crc_word_t;

endpackage

// File: rtl/crc32.sv
// Combinational CRC-32 update over the enabled bytes of one word, byte 0 first.
module crc32 #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CRC_WIDTH  = 32
) (
  input  logic [DATA_WIDTH-1:0]   i_data,
  input  logic [DATA_WIDTH/8-1:0] i_data_valid,
  input  logic [CRC_WIDTH-1:0]    i_crc_state,
  output logic [CRC_WIDTH-1:0]    o_crc
);

  always_comb begin
    logic [CRC_WIDTH-1:0] c;
    c = i_crc_state;
    for (int b = 0; b < int'(DATA_WIDTH / 8); b++) begin
      if (i_data_valid[b]) begin
        c = c ^ CRC_WIDTH'(i_data[8*b +: 8]);
        for (int k = 0; k < 8; k++) begin
          c = c[0] ? ((c >> 1) ^ CRC_WIDTH'(crc_pkg::CRC_POLY)) : (c >> 1);
        end
      end
    end
    o_crc = c;
  end

endmodule

// File: rtl/crc32_fcs_ctrl.sv
// AXI-Stream FCS inserter: forwards frame beats through one register stage and
// appends the inverted CRC-32, packing it into spare lanes of the last beat.
module crc32_fcs_ctrl
  import crc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CRC_WIDTH  = 32
) (
  input  logic                    i_clk,
  input  logic                    i_reset_n,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic                    s_axis_tvalid,
  input  logic                    s_axis_tlast,
  output logic                    s_axis_tready,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                    m_axis_tvalid,
  output logic                    m_axis_tlast,
  input  logic                    m_axis_tready,
  output logic                    o_keep_err
);

  localparam int unsigned KEEP_WIDTH = DATA_WIDTH / 8;

  fcs_state_t                state_q;
  logic [CRC_WIDTH-1:0]      crc_q;
  logic [CRC_WIDTH-1:0]      crc_next;
  logic [CRC_WIDTH-1:0]      fcs;
  logic                      ready_en_q;
  logic                      tail_out_q;
  logic [DATA_WIDTH-1:0]     tail_data_q;
  logic [KEEP_WIDTH-1:0]     tail_keep_q;
  logic [2*DATA_WIDTH-1:0]   merged;
  logic                      keep_legal;
  logic                      s_acc;
  logic                      m_cons;
  crc_word_t                 beat;

  always_comb begin
    keep_legal = (s_axis_tkeep == 4'b1111) ||
                 (s_axis_tlast && (s_axis_tkeep inside {4'b0001, 4'b0011, 4'b0111}));
    beat.data_word = s_axis_tdata;
    beat.last      = s_axis_tlast;
    if (keep_legal) begin
      beat.data_valid = s_axis_tkeep;
    end else if (s_axis_tlast && (s_axis_tkeep == 4'b0000)) begin
      beat.data_valid = 4'b0001;
    end else begin
      beat.data_valid = 4'b1111;
    end
  end

  crc32 #(
    .DATA_WIDTH (DATA_WIDTH),
    .CRC_WIDTH  (CRC_WIDTH)
  ) u_crc32 (
    .i_data       (beat.data_word),
    .i_data_valid (beat.data_valid),
    .i_crc_state  (crc_q),
    .o_crc        (crc_next)
  );

  assign fcs = ~crc_next;

  // Low word is the last output beat, high word the tail beat.
  always_comb begin
    case (beat.data_valid)
      4'b0001: merged = {24'h0, fcs, beat.data_word[7:0]};
      4'b0011: merged = {16'h0, fcs, beat.data_word[15:0]};
      4'b0111: merged = {8'h0, fcs, beat.data_word[23:0]};
      default: merged = {fcs, beat.data_word};
    endcase
  end

  // Once the tail beat itself sits in the output register, a consuming cycle
  // frees the register for the next frame's first beat.
  assign s_axis_tready = ready_en_q && ((state_q != StTail) || tail_out_q) &&
                         (!m_axis_tvalid || m_axis_tready);
  assign s_acc  = s_axis_tvalid && s_axis_tready;
  assign m_cons = m_axis_tvalid && m_axis_tready;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q       <= StIdle;
      crc_q         <= CRC_INIT;
      ready_en_q    <= 1'b0;
      tail_out_q    <= 1'b0;
      tail_data_q   <= '0;
      tail_keep_q   <= '0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      o_keep_err    <= 1'b0;
    end else begin
      ready_en_q <= 1'b1;
      o_keep_err <= s_acc && !keep_legal;
      if (s_acc) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tkeep  <= '1;
        m_axis_tlast  <= 1'b0;
        tail_out_q    <= 1'b0;
        if (beat.last) begin
          crc_q        <= CRC_INIT;
          m_axis_tdata <= merged[DATA_WIDTH-1:0];
          tail_data_q  <= merged[2*DATA_WIDTH-1:DATA_WIDTH];
          tail_keep_q  <= beat.data_valid;
          state_q      <= StTail;
        end else begin
          crc_q        <= crc_next;
          m_axis_tdata <= beat.data_word;
          state_q      <= StData;
        end
      end else if ((state_q == StTail) && !tail_out_q && (!m_axis_tvalid || m_axis_tready)) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= tail_data_q;
        m_axis_tkeep  <= tail_keep_q;
        m_axis_tlast  <= 1'b1;
        tail_out_q    <= 1'b1;
      end else if (m_cons) begin
        m_axis_tvalid <= 1'b0;
        if ((state_q == StTail) && tail_out_q) begin
          state_q    <= StIdle;
          tail_out_q <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_crc32_fcs_ctrl.sv
// Self-checking bench for crc32_fcs_ctrl: directed vectors plus random frames
// compared against a byte-stream reference model.
module tb_crc32_fcs_ctrl;

  logic        i_clk = 1'b0;
  logic        i_reset_n = 1'b0;
  logic [31:0] s_axis_tdata = '0;
  logic [3:0]  s_axis_tkeep = '0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tlast = 1'b0;
  logic        s_axis_tready;
  logic [31:0] m_axis_tdata;
  logic [3:0]  m_axis_tkeep;
  logic        m_axis_tvalid;
  logic        m_axis_tlast;
  logic        m_axis_tready = 1'b1;
  logic        o_keep_err;

  crc32_fcs_ctrl #(
    .DATA_WIDTH (32),
    .CRC_WIDTH  (32)
  ) dut (
    .i_clk         (i_clk),
    .i_reset_n     (i_reset_n),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready),
    .o_keep_err    (o_keep_err)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
    int          cyc;
  } beat_t;
  typedef logic [7:0] bytes_t[$];

  beat_t       got[$];
  beat_t       exp_q[$];
  beat_t       nb;
  logic [31:0] crc_tab[256];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  bit          rand_ready = 0;
  bit          hold_ready = 0;
  int          stall_err = 0;
  int          kerr_pulses = 0;
  int          kerr_len = 0;
  int          kerr_maxlen = 0;
  logic        pv = 0, pr = 0, pl = 0;
  logic [31:0] pd = '0;
  logic [3:0]  pk = '0;

  initial forever begin
    @(posedge i_clk);
    cyc++;
  end

  initial forever begin
    @(posedge i_clk);
    #1;
    m_axis_tready = hold_ready ? 1'b0 : (rand_ready ? 1'($urandom_range(0, 1)) : 1'b1);
  end

  // Output monitor: handshakes and hold-while-stalled, sampled mid-cycle.
  initial forever begin
    @(negedge i_clk);
    if (i_reset_n) begin
      if (pv && !pr && (m_axis_tvalid !== 1'b1 || m_axis_tdata !== pd ||
                        m_axis_tkeep !== pk || m_axis_tlast !== pl)) stall_err++;
      if (m_axis_tvalid && m_axis_tready) begin
        nb.data = m_axis_tdata;
        nb.keep = m_axis_tkeep;
        nb.last = m_axis_tlast;
        nb.cyc  = cyc;
        got.push_back(nb);
      end
    end
    pv = i_reset_n && m_axis_tvalid;
    pr = m_axis_tready;
    pd = m_axis_tdata;
    pk = m_axis_tkeep;
    pl = m_axis_tlast;
    if (o_keep_err === 1'b1) begin
      kerr_len++;
      if (kerr_len == 1) kerr_pulses++;
      if (kerr_len > kerr_maxlen) kerr_maxlen = kerr_len;
    end else begin
      kerr_len = 0;
    end
  end

  function automatic logic [31:0] crc_bytes(input bytes_t b);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    foreach (b[i]) c = (c >> 8) ^ crc_tab[c[7:0] ^ b[i]];
    return ~c;
  endfunction

  // Expected wire stream = frame bytes then FCS bytes LSB first, cut into words.
  task automatic model_frame(input bytes_t f);
    bytes_t      s;
    logic [31:0] fcs;
    beat_t       b;
    int          n;
    s   = f;
    fcs = crc_bytes(f);
    for (int i = 0; i < 4; i++) s.push_back(fcs[8*i +: 8]);
    for (int i = 0; i < s.size(); i += 4) begin
      b.data = '0;
      b.keep = '0;
      n = s.size() - i;
      if (n > 4) n = 4;
      for (int j = 0; j < n; j++) begin
        b.data[8*j +: 8] = s[i+j];
        b.keep[j] = 1'b1;
      end
      b.last = (i + 4 >= s.size());
      b.cyc  = 0;
      exp_q.push_back(b);
    end
  endtask

  task automatic push_exp(input logic [31:0] d, input logic [3:0] k, input logic l);
    beat_t b;
    b.data = d;
    b.keep = k;
    b.last = l;
    b.cyc  = 0;
    exp_q.push_back(b);
  endtask

  task automatic drive_beat(input logic [31:0] d, input logic [3:0] k, input logic l,
                            output bit ok);
    s_axis_tdata  = d;
    s_axis_tkeep  = k;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    ok = 0;
    for (int t = 0; t < 300 && !ok; t++) begin
      @(negedge i_clk);
      ok = s_axis_tready;
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic send_frame(input bytes_t f, input bit gaps, input bit hold_valid,
                            output bit ok);
    int          nbeats;
    bit          a;
    logic [31:0] d;
    logic [3:0]  k;
    ok = 1;
    nbeats = (f.size() + 3) / 4;
    for (int b = 0; b < nbeats; b++) begin
      d = '0;
      k = '0;
      for (int j = 0; j < 4; j++) begin
        if (4 * b + j < f.size()) begin
          d[8*j +: 8] = f[4*b+j];
          k[j] = 1'b1;
        end
      end
      drive_beat(d, k, (b == nbeats - 1), a);
      ok &= a;
      if (gaps && $urandom_range(0, 2) == 0) begin
        s_axis_tvalid = 1'b0;
        repeat ($urandom_range(1, 3)) begin
          @(posedge i_clk);
          #1;
        end
      end
    end
    if (!hold_valid) s_axis_tvalid = 1'b0;
  endtask

  task automatic wait_out(input int n, output bit ok);
    ok = (got.size() >= n);
    for (int t = 0; t < 2000 && !ok; t++) begin
      @(posedge i_clk);
      #1;
      ok = (got.size() >= n);
    end
    repeat (6) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge i_clk);
    checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid got %b want 0", m_axis_tvalid); end
    checks++; if (m_axis_tlast !== 1'b0) begin errors++; $display("FAIL rst_tlast got %b want 0", m_axis_tlast); end
    checks++; if (m_axis_tdata !== 32'h0) begin errors++; $display("FAIL rst_tdata got %h want 0", m_axis_tdata); end
    checks++; if (m_axis_tkeep !== 4'h0) begin errors++; $display("FAIL rst_tkeep got %b want 0", m_axis_tkeep); end
    checks++; if (o_keep_err !== 1'b0) begin errors++; $display("FAIL rst_keep_err got %b want 0", o_keep_err); end
    checks++; if (s_axis_tready !== 1'b0) begin errors++; $display("FAIL rst_tready got %b want 0", s_axis_tready); end
    @(posedge i_clk);
    #1 i_reset_n = 1'b1;
    @(negedge i_clk);
    checks++; if (s_axis_tready !== 1'b0) begin errors++; $display("FAIL rel_tready_pre got %b want 0", s_axis_tready); end
    @(negedge i_clk);
    checks++; if (s_axis_tready !== 1'b1) begin errors++; $display("FAIL rel_tready_post got %b want 1", s_axis_tready); end
    @(posedge i_clk);
    #1;
  endtask

  task automatic load_check_vector_exp();
    exp_q.delete();
    push_exp(32'h3433_3231, 4'hF, 1'b0);
    push_exp(32'h3837_3635, 4'hF, 1'b0);
    push_exp(32'hF439_2639, 4'hF, 1'b0);
    push_exp(32'h0000_00CB, 4'h1, 1'b1);
  endtask

  task automatic test_check_vector(input bit stall, input string tag);
    bytes_t f;
    bit     ok;
    f = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    got.delete();
    stall_err = 0;
    rand_ready = stall;
    load_check_vector_exp();
    send_frame(f, stall, 0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL %s_accept got timeout want accepted", tag); end
    wait_out(4, ok);
    rand_ready = 0;
    checks++; if (got.size() != 4) begin errors++; $display("FAIL %s_count got %0d want 4", tag, got.size()); end
    foreach (exp_q[i]) begin
      checks++;
      if (i >= got.size() || got[i].data !== exp_q[i].data || got[i].keep !== exp_q[i].keep ||
          got[i].last !== exp_q[i].last) begin
        errors++;
        $display("FAIL %s_beat%0d got %h/%b/%b want %h/%b/%b", tag, i, got[i].data, got[i].keep,
                 got[i].last, exp_q[i].data, exp_q[i].keep, exp_q[i].last);
      end
    end
    checks++; if (stall_err != 0) begin errors++; $display("FAIL %s_hold got %0d changes want 0", tag, stall_err); end
  endtask

  task automatic test_zero_word();
    bytes_t z;
    bit     ok;
    z = '{8'h00, 8'h00, 8'h00, 8'h00};
    got.delete();
    send_frame(z, 0, 0, ok);
    wait_out(2, ok);
    checks++; if (got.size() != 2) begin errors++; $display("FAIL zero_count got %0d want 2", got.size()); end
    checks++;
    if (got[0].data !== 32'h0 || got[0].keep !== 4'hF || got[0].last !== 1'b0) begin
      errors++; $display("FAIL zero_data got %h/%b/%b want 00000000/1111/0", got[0].data, got[0].keep, got[0].last);
    end
    checks++;
    if (got[1].data !== 32'h2144DF1C || got[1].keep !== 4'hF || got[1].last !== 1'b1) begin
      errors++; $display("FAIL zero_fcs got %h/%b/%b want 2144df1c/1111/1", got[1].data, got[1].keep, got[1].last);
    end
  endtask

  task automatic test_back_to_back();
    bytes_t z;
    bit     ok1, ok2, ok;
    z = '{8'h00, 8'h00, 8'h00, 8'h00};
    got.delete();
    send_frame(z, 0, 1, ok1);
    send_frame(z, 0, 0, ok2);
    wait_out(4, ok);
    checks++; if (got.size() != 4) begin errors++; $display("FAIL b2b_count got %0d want 4", got.size()); end
    for (int f = 0; f < 2; f++) begin
      checks++;
      if (got[2*f+1].data !== 32'h2144DF1C || got[2*f+1].keep !== 4'hF || got[2*f+1].last !== 1'b1) begin
        errors++; $display("FAIL b2b_fcs%0d got %h/%b/%b want 2144df1c/1111/1", f, got[2*f+1].data,
                            got[2*f+1].keep, got[2*f+1].last);
      end
    end
    checks++;
    if (got.size() < 4 || got[2].cyc - got[1].cyc != 1) begin
      errors++; $display("FAIL b2b_gap got %0d cycles want 1", got[2].cyc - got[1].cyc);
    end
  endtask

  task automatic test_reset_mid_frame();
    bytes_t z;
    bit     ok;
    z = '{8'h00, 8'h00, 8'h00, 8'h00};
    hold_ready = 1;
    @(posedge i_clk);
    #2;
    drive_beat(32'h3433_3231, 4'hF, 1'b0, ok);
    s_axis_tvalid = 1'b0;
    @(negedge i_clk);
    checks++; if (m_axis_tvalid !== 1'b1) begin errors++; $display("FAIL mid_held got %b want 1", m_axis_tvalid); end
    @(posedge i_clk);
    #1 i_reset_n = 1'b0;
    @(negedge i_clk);
    checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL mid_rst_tvalid got %b want 0", m_axis_tvalid); end
    got.delete();
    @(posedge i_clk);
    #1 i_reset_n = 1'b1;
    hold_ready = 0;
    send_frame(z, 0, 0, ok);
    wait_out(2, ok);
    checks++; if (got.size() != 2) begin errors++; $display("FAIL mid_count got %0d want 2", got.size()); end
    checks++;
    if (got[0].data !== 32'h0 || got[0].keep !== 4'hF || got[0].last !== 1'b0) begin
      errors++; $display("FAIL mid_data got %h/%b/%b want 00000000/1111/0", got[0].data, got[0].keep, got[0].last);
    end
    checks++;
    if (got[1].data !== 32'h2144DF1C || got[1].last !== 1'b1) begin
      errors++; $display("FAIL mid_fcs got %h/%b want 2144df1c/1", got[1].data, got[1].last);
    end
  endtask

  task automatic test_keep_err();
    bit ok;
    got.delete();
    exp_q.delete();
    kerr_pulses = 0;
    kerr_maxlen = 0;
    model_frame('{8'h5A, 8'h5A, 8'hA5, 8'hA5, 8'h44, 8'h33, 8'h22, 8'h11});
    model_frame('{8'h77});
    drive_beat(32'hA5A5_5A5A, 4'b0011, 1'b0, ok);
    drive_beat(32'h1122_3344, 4'b1111, 1'b1, ok);
    drive_beat(32'hEEEE_EE77, 4'b0000, 1'b1, ok);
    s_axis_tvalid = 1'b0;
    wait_out(exp_q.size(), ok);
    checks++; if (kerr_pulses != 2) begin errors++; $display("FAIL kerr_pulses got %0d want 2", kerr_pulses); end
    checks++; if (kerr_maxlen != 1) begin errors++; $display("FAIL kerr_width got %0d want 1", kerr_maxlen); end
    checks++; if (got[0].keep !== 4'hF) begin errors++; $display("FAIL kerr_keep got %b want 1111", got[0].keep); end
    checks++; if (got.size() != exp_q.size()) begin errors++; $display("FAIL kerr_count got %0d want %0d", got.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      checks++;
      if (i >= got.size() || got[i].data !== exp_q[i].data || got[i].keep !== exp_q[i].keep ||
          got[i].last !== exp_q[i].last) begin
        errors++;
        $display("FAIL kerr_beat%0d got %h/%b/%b want %h/%b/%b", i, got[i].data, got[i].keep,
                 got[i].last, exp_q[i].data, exp_q[i].keep, exp_q[i].last);
      end
    end
  endtask

  task automatic test_random();
    bytes_t f;
    bit     ok, all_ok;
    got.delete();
    exp_q.delete();
    stall_err = 0;
    rand_ready = 1;
    all_ok = 1;
    for (int n = 0; n < 12; n++) begin
      f.delete();
      repeat ($urandom_range(1, 23)) f.push_back(8'($urandom));
      model_frame(f);
      send_frame(f, 1, 0, ok);
      all_ok &= ok;
    end
    wait_out(exp_q.size(), ok);
    rand_ready = 0;
    checks++; if (!all_ok) begin errors++; $display("FAIL rand_accept got timeout want accepted"); end
    checks++; if (got.size() != exp_q.size()) begin errors++; $display("FAIL rand_count got %0d want %0d", got.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      checks++;
      if (i >= got.size() || got[i].data !== exp_q[i].data || got[i].keep !== exp_q[i].keep ||
          got[i].last !== exp_q[i].last) begin
        errors++;
        $display("FAIL rand_beat%0d got %h/%b/%b want %h/%b/%b", i, got[i].data, got[i].keep,
                 got[i].last, exp_q[i].data, exp_q[i].keep, exp_q[i].last);
      end
    end
    checks++; if (stall_err != 0) begin errors++; $display("FAIL rand_hold got %0d changes want 0", stall_err); end
  endtask

  initial begin
    logic [31:0] v;
    for (int i = 0; i < 256; i++) begin
      v = 32'(i);
      for (int k = 0; k < 8; k++) v = v[0] ? ((v >> 1) ^ 32'hEDB8_8320) : (v >> 1);
      crc_tab[i] = v;
    end
    test_reset();
    test_check_vector(0, "vec");
    test_zero_word();
    test_check_vector(1, "stall");
    test_back_to_back();
    test_reset_mid_frame();
    test_keep_err();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1);
  end

endmodule
